module_data_arbiter: RTL and testbench
======================================

Name: module_data_arbiter

Overview:
- Round-robin arbiter. Shares the single 128-bit event path into the Ethernet TX FIFO between the four per-module singles/timetag FIFOs.
- Replaces fixed-priority chaining, which lets module 0 starve modules 1-3 under high singles rate.
- Adds per-module enable gating, a programmable burst limit per grant, and per-source word counters readable by the MicroBlaze GPIO.
- Sits between the per-module rx data FIFOs and the eth FIFO write port, in the sys_clk domain.

Parameters:
NMODULES, 4, number of requesters
LENGTH, 128, event word width
BURST_W, 4, width of burst_len input
CNT_W, 48, width of per-source word counters

Ports:
clk  in  1  sys_clk
rst_n  in  1  asynchronous, active-low reset
in_valid  in  NMODULES  per-module FIFO not-empty
in_ready  out  NMODULES  per-module FIFO read strobe (FWFT pop)
in_data  in  NMODULES*LENGTH  module i occupies bits [i*LENGTH +: LENGTH]
out_valid  out  1  output word valid
out_ready  in  1  downstream not full
out_data  out  LENGTH  registered event word
out_src  out  clog2(NMODULES)  module index of out_data
enable_mask  in  NMODULES  1 = module eligible for grant
burst_len  in  BURST_W  max words per grant; 0 treated as 1
grant_active  out  1  high in GRANT state
grant_id  out  clog2(NMODULES)  current/last grantee
cnt_sel  in  clog2(NMODULES)  counter read select
cnt_clr  in  NMODULES  per-source counter synchronous clear
cnt_val  out  CNT_W  counter[cnt_sel], combinational read

Behaviour:
- Reset (rst_n=0, async): state=IDLE, rr_ptr=0, grant_id=0, burst_cnt=0, out_valid=0, out_data=0, out_src=0, in_ready=0, grant_active=0, all counters=0. rst_n deassertion is already synchronised externally.
- elig = in_valid & enable_mask.
- load = ~out_valid | out_ready (output register free or draining this cycle).
- IDLE:
  - If elig != 0: pick the first set bit of elig searching upward from rr_ptr with wrap.
  - Register it as grant_id, latch blen = max(burst_len,1), clear burst_cnt, go to GRANT next cycle.
  - in_ready = 0 in IDLE.
- GRANT (g = grant_id):
  - in_ready[g] = load & in_valid[g] & enable_mask[g]. All other in_ready bits = 0.
  - On a transfer: out_data <= in_data[g], out_src <= g, out_valid <= 1, counter[g]++, burst_cnt++.
  - Return to IDLE with rr_ptr <= (g+1) mod NMODULES when any of these holds:
    - a transfer makes burst_cnt+1 == blen;
    - in_valid[g]=0;
    - enable_mask[g]=0.
    A release for in_valid or enable_mask loss happens in that cycle with no transfer.
  - Stalled by load=0 with in_valid[g]=1: stay in GRANT, hold burst_cnt.
- Output register:
  - out_valid clears when out_ready=1 and there is no new transfer.
  - out_data and out_src hold while out_valid & ~out_ready.
- Latency: elig rises in IDLE at cycle t -> grant_active at t+1 -> transfer at t+1 if load -> out_valid at t+2. There is exactly one IDLE bubble between consecutive grants.
- Throughput: 1 word/cycle within a burst when out_ready=1.
- burst_len and enable_mask changes: burst_len is sampled only at grant time. enable_mask is evaluated every cycle.
- Counters wrap modulo 2^CNT_W. If cnt_clr[i] and an increment of i occur in the same cycle, clear wins (result 0).
- No word is ever duplicated or dropped. Each in_ready pulse equals exactly one out word.

Decomposition:
- Package module_data_arb_pkg: NMODULES, LENGTH, SRC_W = $clog2(NMODULES), state enum {IDLE, GRANT}.
- Sub-module rr_pick: combinational round-robin first-set search (req, ptr -> idx, any). It is reused later for the command-path arbiter.

Test Plan:
- All four modules continuously valid, burst_len=4, out_ready=1 -> out_src sequence 0,0,0,0,1,1,1,1,2,...; one bubble between groups; counters each 4k after k rounds.
- Only module 2 valid, burst_len=0 -> grants alternate IDLE/GRANT; module 2 drains 1 word per 2 cycles; out_src=2 throughout.
- enable_mask=4'b1010, all valid -> only sources 1 and 3 appear; modules 0 and 2 in_ready never asserted.
- out_ready held low 10 cycles mid-burst (module 1, burst_len=8) -> out_data stable, in_ready[1]=0, burst_cnt frozen; on release burst completes with 8 total words, no loss.
- Module 3 in_valid drops after 2 of 8 words -> release same cycle, rr_ptr=0, next grant goes to next eligible.
- rst_n asserted mid-burst -> out_valid and in_ready drop immediately (async); after release first grant goes to module 0. cnt_clr[1] concurrent with a module 1 transfer -> counter[1]=0.

Source files
------------

// File: rtl/module_data_arb_pkg.sv
// Shared types and constants for the module data arbiter.
// Sizes match the four-module readout with a 128-bit event path.
package module_data_arb_pkg;

    localparam int NMODULES = 4;
    localparam int LENGTH   = 128;
    localparam int BURST_W  = 4;
    localparam int CNT_W    = 48;
    localparam int SRC_W    = $clog2(NMODULES);

    typedef enum logic {
        IDLE,
        GRANT
    } arb_state_t;

endpackage

// File: rtl/module_data_arbiter_rr_pick.sv
// Round-robin first-set search: lowest request at or above ptr,
// wrapping; shared with the command-path arbiter.
module rr_pick #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         any
);

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            logic [W-1:0] j;
            j = W'((int'(ptr) + k) % N);
            if (req[j]) begin
                idx = j;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/module_data_arbiter.sv
// Round-robin arbiter sharing the eth TX FIFO event path between
// the per-module rx FIFOs, with burst limit and word counters.
module module_data_arbiter
    import module_data_arb_pkg::*;
#(
    parameter int NMODULES = module_data_arb_pkg::NMODULES,
    parameter int LENGTH   = module_data_arb_pkg::LENGTH,
    parameter int BURST_W  = module_data_arb_pkg::BURST_W,
    parameter int CNT_W    = module_data_arb_pkg::CNT_W,
    localparam int SW      = $clog2(NMODULES)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NMODULES-1:0]          in_valid,
    output logic [NMODULES-1:0]          in_ready,
    input  logic [NMODULES*LENGTH-1:0]   in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LENGTH-1:0]            out_data,
    output logic [SW-1:0]                out_src,
    input  logic [NMODULES-1:0]          enable_mask,
    input  logic [BURST_W-1:0]           burst_len,
    output logic                         grant_active,
    output logic [SW-1:0]                grant_id,
    input  logic [SW-1:0]                cnt_sel,
    input  logic [NMODULES-1:0]          cnt_clr,
    output logic [CNT_W-1:0]             cnt_val
);

    arb_state_t          state_q, state_d;
    logic [SW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [SW-1:0]       grant_id_q, grant_id_d;
    logic [BURST_W-1:0]  burst_cnt_q, burst_cnt_d;
    logic [BURST_W-1:0]  blen_q, blen_d;
    logic                out_valid_q, out_valid_d;
    logic [LENGTH-1:0]   out_data_q, out_data_d;
    logic [SW-1:0]       out_src_q, out_src_d;
    logic [CNT_W-1:0]    cnt_q [NMODULES];
    logic [CNT_W-1:0]    cnt_d [NMODULES];

    logic [NMODULES-1:0] elig;
    logic                load;
    logic                xfer;
    logic                rel;
    logic [SW-1:0]       pick_idx;
    logic                pick_any;

    assign elig = in_valid & enable_mask;
    assign load = ~out_valid_q | out_ready;

    rr_pick #(
        .N (NMODULES),
        .W (SW)
    ) u_pick (
        .req (elig),
        .ptr (rr_ptr_q),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Grant FSM: pick in IDLE, stream up to blen words in GRANT.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_id_d  = grant_id_q;
        burst_cnt_d = burst_cnt_q;
        blen_d      = blen_q;
        in_ready    = '0;
        xfer        = 1'b0;
        rel         = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_id_d  = pick_idx;
                    burst_cnt_d = '0;
                    blen_d      = (burst_len == '0) ? BURST_W'(1)
                                                    : burst_len;
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                xfer = load & in_valid[grant_id_q]
                     & enable_mask[grant_id_q];
                in_ready[grant_id_q] = xfer;
                if (xfer) begin
                    burst_cnt_d = burst_cnt_q + BURST_W'(1);
                end
                rel = ~in_valid[grant_id_q]
                    | ~enable_mask[grant_id_q]
                    | (xfer &&
                       (burst_cnt_q + BURST_W'(1) == blen_q));
                if (rel) begin
                    state_d  = IDLE;
                    rr_ptr_d = (grant_id_q == SW'(NMODULES - 1))
                             ? '0 : grant_id_q + SW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output register: load on transfer, drop valid once drained.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data[grant_id_q*LENGTH +: LENGTH];
            out_src_d   = grant_id_q;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Per-source word counters; a clear beats a same-cycle increment.
    always_comb begin
        for (int i = 0; i < NMODULES; i++) begin
            cnt_d[i] = cnt_q[i];
            if (cnt_clr[i]) begin
                cnt_d[i] = '0;
            end else if (xfer && grant_id_q == SW'(i)) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // State, output and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_id_q  <= '0;
            burst_cnt_q <= '0;
            blen_q      <= BURST_W'(1);
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            for (int i = 0; i < NMODULES; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_id_q  <= grant_id_d;
            burst_cnt_q <= burst_cnt_d;
            blen_q      <= blen_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            for (int i = 0; i < NMODULES; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_src      = out_src_q;
    assign grant_active = (state_q == GRANT);
    assign grant_id     = grant_id_q;
    assign cnt_val      = cnt_q[cnt_sel];

endmodule

// File: tb/tb_module_data_arbiter.sv
// Bench for module_data_arbiter: FIFO models feed the arbiter,
// an expected-word queue is checked by a negedge monitor.
module tb_module_data_arbiter;
    import module_data_arb_pkg::*;

    localparam int N  = NMODULES;
    localparam int L  = LENGTH;
    localparam int SW = SRC_W;

    logic               clk;
    logic               rst_n;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [N*L-1:0]     in_data;
    logic               out_valid;
    logic               out_ready;
    logic [L-1:0]       out_data;
    logic [SW-1:0]      out_src;
    logic [N-1:0]       enable_mask;
    logic [BURST_W-1:0] burst_len;
    logic               grant_active;
    logic [SW-1:0]      grant_id;
    logic [SW-1:0]      cnt_sel;
    logic [N-1:0]       cnt_clr;
    logic [CNT_W-1:0]   cnt_val;

    module_data_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_src      (out_src),
        .enable_mask  (enable_mask),
        .burst_len    (burst_len),
        .grant_active (grant_active),
        .grant_id     (grant_id),
        .cnt_sel      (cnt_sel),
        .cnt_clr      (cnt_clr),
        .cnt_val      (cnt_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [SW-1:0] src;
        logic [L-1:0]  data;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks;
    int   errors;
    int   cyc;
    int   n_acc;
    int   first_acc;
    int   last_acc;
    logic seen02;
    int   pop_cnt [N];
    int   lim     [N];
    int   sbase   [N];

    function automatic logic [L-1:0] word(int m, int s);
        return {32'(m), 64'h0123_4567_89AB_CDEF, 32'(s)};
    endfunction

    // FIFO models: valid while words remain, data carries source/seq.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            in_valid[i]        = lim[i] > pop_cnt[i];
            in_data[i*L +: L]  = word(i, pop_cnt[i] - sbase[i]);
        end
    end

    initial begin
        cyc = 0;
        for (int i = 0; i < N; i++) pop_cnt[i] = 0;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < N; i++)
            if (in_ready[i]) pop_cnt[i] <= pop_cnt[i] + 1;
    end

    // Monitor: each accepted word must match the queue head.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL extra_word src=%0d data=%h",
                         out_src, out_data);
            end else begin
                e = sb.pop_front();
                if (out_src !== e.src || out_data !== e.data) begin
                    errors++;
                    $display("FAIL word src=%0d exp %0d data=%h exp %h",
                             out_src, e.src, out_data, e.data);
                end
            end
            if (n_acc == 0) first_acc = cyc;
            last_acc = cyc;
            n_acc++;
        end
        if (in_ready[0] | in_ready[2]) seen02 = 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [L-1:0] got,
                       logic [L-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic chk_cnt(int m, int exp);
        cnt_sel = SW'(m);
        #1;
        chk($sformatf("cnt%0d", m), L'(cnt_val), L'(exp));
    endtask

    task automatic push(int m, int s);
        exp_t x;
        x.src  = SW'(m);
        x.data = word(m, s);
        sb.push_back(x);
    endtask

    task automatic give(int m, int n);
        lim[m] = pop_cnt[m] + n;
    endtask

    task automatic restart();
        for (int i = 0; i < N; i++) begin
            sbase[i] = pop_cnt[i];
            lim[i]   = pop_cnt[i];
        end
    endtask

    task automatic wait_pops(int m, int n);
        int t;
        t = 0;
        while ((pop_cnt[m] - sbase[m]) < n && t < 300) begin
            tick();
            t++;
        end
        checks++;
        if (t >= 300) begin
            errors++;
            $display("FAIL wait_pops m=%0d got %0d need %0d",
                     m, pop_cnt[m] - sbase[m], n);
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 300) begin
            tick();
            t++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain left %0d expected 0", sb.size());
            sb.delete();
        end
        repeat (5) tick();
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        out_ready   = 1'b1;
        enable_mask = '1;
        burst_len   = BURST_W'(4);
        cnt_clr     = '0;
        cnt_sel     = '0;
        restart();
        tick();
        tick();
        rst_n = 1'b1;
        n_acc = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        seen02 = 1'b0;
        for (int i = 0; i < N; i++) begin
            lim[i]   = 0;
            sbase[i] = 0;
        end
        do_reset();

        chk("rst_out_valid", L'(out_valid), '0);
        chk("rst_in_ready", L'(in_ready), '0);
        chk("rst_grant_active", L'(grant_active), '0);
        chk("rst_grant_id", L'(grant_id), '0);
        chk("rst_out_src", L'(out_src), '0);
        chk("rst_out_data", out_data, '0);
        for (int m = 0; m < N; m++) chk_cnt(m, 0);

        // Two full rounds, burst 4, all sources busy.
        for (int r = 0; r < 2; r++)
            for (int m = 0; m < N; m++)
                for (int k = 0; k < 4; k++) push(m, r * 4 + k);
        for (int m = 0; m < N; m++) give(m, 8);
        drain();
        chk("rr_span", L'(last_acc - first_acc), L'(38));
        for (int m = 0; m < N; m++) chk_cnt(m, 8);

        // Single source, burst 0 acts as 1: one word per 2 cycles.
        do_reset();
        burst_len = '0;
        for (int s = 0; s < 4; s++) push(2, s);
        give(2, 4);
        drain();
        chk("b0_span", L'(last_acc - first_acc), L'(6));
        chk_cnt(2, 4);

        // Mask 1010: only 1 and 3 served, 0 and 2 never popped.
        do_reset();
        enable_mask = 4'b1010;
        burst_len   = BURST_W'(2);
        seen02      = 1'b0;
        push(1, 0); push(1, 1); push(3, 0); push(3, 1);
        push(1, 2); push(1, 3); push(3, 2); push(3, 3);
        for (int m = 0; m < N; m++) give(m, 4);
        drain();
        chk("mask_ready02", L'(seen02), '0);
        chk_cnt(0, 0);
        chk_cnt(1, 4);
        chk_cnt(2, 0);
        chk_cnt(3, 4);

        // Downstream stall mid-burst on module 1, burst 8.
        do_reset();
        burst_len = BURST_W'(8);
        for (int s = 0; s < 8; s++) push(1, s);
        give(1, 8);
        wait_pops(1, 3);
        out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("stall_valid", L'(out_valid), L'(1));
            chk("stall_data", out_data, word(1, 2));
            chk("stall_ready", L'(in_ready), '0);
            chk("stall_grant", L'(grant_active), L'(1));
        end
        out_ready = 1'b1;
        drain();
        chk_cnt(1, 8);

        // Module 3 runs dry after 2 of 8 words; pointer wraps to 0.
        do_reset();
        burst_len = BURST_W'(8);
        push(3, 0); push(3, 1); push(0, 0); push(1, 0);
        give(3, 2);
        wait_pops(3, 2);
        chk("dry_no_xfer", L'(in_ready), '0);
        give(0, 1);
        give(1, 1);
        tick();
        chk("dry_idle", L'(grant_active), '0);
        tick();
        chk("dry_next_grant", L'(grant_active), L'(1));
        chk("dry_next_id", L'(grant_id), '0);
        drain();

        // Asynchronous reset in the middle of a module 2 burst.
        do_reset();
        burst_len = BURST_W'(8);
        push(2, 0);
        give(2, 8);
        wait_pops(2, 2);
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", L'(out_valid), '0);
        chk("arst_in_ready", L'(in_ready), '0);
        chk("arst_grant", L'(grant_active), '0);
        tick();
        rst_n = 1'b1;
        give(0, 1);
        push(0, 0);
        for (int s = 2; s < 8; s++) push(2, s);
        drain();
        chk_cnt(0, 1);
        chk_cnt(2, 6);

        // Clear of counter 1 coinciding with a module 1 transfer.
        burst_len = BURST_W'(4);
        cnt_sel   = SW'(1);
        push(1, 0); push(1, 1); push(1, 2);
        give(1, 3);
        wait_pops(1, 1);
        chk("clr_ready", L'(in_ready[1]), L'(1));
        cnt_clr = 4'b0010;
        tick();
        cnt_clr = '0;
        chk("clr_wins", L'(cnt_val), '0);
        drain();
        chk_cnt(1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
